// File: rtl/wisc_pipe_pkg.sv
// wisc_pipe_pkg: shared pipeline types and constants for the WISC core sequencer
package wisc_pipe_pkg;
  localparam int REG_W = 4;
  localparam logic [15:0] NOP = 16'h0000;
  typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALT} state_e;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: flags an ID instruction reading the register a load in EX is about to write ($0 never hazards)
module hazard_detect
  import wisc_pipe_pkg::*;
(
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_src1_used,
  input  logic             id_src2_used,
  input  logic [REG_W-1:0] ex_dst,
  input  logic             ex_is_load,
  output logic             load_use
);
  assign load_use = ex_is_load && ex_dst != '0 &&
                    ((id_src1_used && id_src1 == ex_dst) || (id_src2_used && id_src2 == ex_dst));
endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: stall/flush/freeze/halt sequencer for PC, IF/ID, ID/EX (HAZARD_PERF_CNT_EN adds stall_cycles/flush_count)
module hazard_ctrl_unit
  import wisc_pipe_pkg::*;
#(
  parameter int DRAIN_CYC = 3,
  parameter int MAX_WAIT  = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_src1_used,
  input  logic             id_src2_used,
  input  logic [REG_W-1:0] ex_dst,
  input  logic             ex_is_load,
  input  logic             branch_taken,
  input  logic             id_is_hlt,
  input  logic             mem_busy,
  output logic             pc_wen,
  output logic             if_id_wen,
  output logic             if_id_flush,
  output logic             id_ex_wen,
  output logic             id_ex_bubble,
  output logic             halted,
  output logic             timeout_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0]      stall_cycles,
  output logic [15:0]      flush_count
`endif
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int DW = $clog2(DRAIN_CYC + 1);
  localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);
  localparam logic [DW-1:0] DLAST = DW'(DRAIN_CYC - 1);
  state_e state_q, state_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [DW-1:0] drain_cnt_q, drain_cnt_d;
  logic halted_q, halted_d, timeout_err_q, timeout_err_d;
  logic load_use, stall;
  hazard_detect u_detect (
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_src1_used (id_src1_used),
    .id_src2_used (id_src2_used),
    .ex_dst       (ex_dst),
    .ex_is_load   (ex_is_load),
    .load_use     (load_use)
  );
  assign stall = load_use || (!branch_taken && id_is_hlt);
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    drain_cnt_d   = drain_cnt_q;
    halted_d      = halted_q;
    timeout_err_d = timeout_err_q;
    pc_wen        = 1'b0;
    if_id_wen     = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_wen     = 1'b0;
    id_ex_bubble  = 1'b0;
    if ((state_q == RUN || state_q == MEM_WAIT) && mem_busy) begin
      state_d       = MEM_WAIT;
      wait_cnt_d    = state_q == RUN ? WW'(1) : wait_cnt_q == WMAX ? WMAX : wait_cnt_q + 1'b1;
      timeout_err_d = timeout_err_q || (state_q == MEM_WAIT && wait_cnt_q == WMAX);
    end else if (state_q == RUN || state_q == MEM_WAIT) begin
      pc_wen       = !stall;
      if_id_wen    = !stall;
      if_id_flush  = !load_use && branch_taken;
      id_ex_wen    = 1'b1;
      id_ex_bubble = stall;
      wait_cnt_d   = '0;
      drain_cnt_d  = '0;
      state_d      = stall && !load_use ? DRAIN : RUN;
    end else if (state_q == DRAIN) begin
      id_ex_wen    = 1'b1;
      id_ex_bubble = 1'b1;
      drain_cnt_d  = mem_busy ? drain_cnt_q : drain_cnt_q + 1'b1;
      state_d      = !mem_busy && drain_cnt_q == DLAST ? HALT : DRAIN;
      halted_d     = halted_q || (!mem_busy && drain_cnt_q == DLAST);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      drain_cnt_q   <= '0;
      halted_q      <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      drain_cnt_q   <= drain_cnt_d;
      halted_q      <= halted_d;
      timeout_err_q <= timeout_err_d;
    end
  end
  assign halted      = halted_q;
  assign timeout_err = timeout_err_q;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cycles_q, stall_cycles_d, flush_count_q, flush_count_d;
  always_comb begin
    stall_cycles_d = (!pc_wen && state_q != HALT && stall_cycles_q != 16'hFFFF) ? stall_cycles_q + 1'b1 : stall_cycles_q;
    flush_count_d  = (if_id_flush && flush_count_q != 16'hFFFF) ? flush_count_q + 1'b1 : flush_count_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end
  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: directed and random stimulus checked against a behavioural sequencer model
module tb_hazard_ctrl_unit;
  localparam int MAXW = 4;
  localparam int DRN  = 3;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] id_src1, id_src2, ex_dst;
  logic id_src1_used, id_src2_used, ex_is_load, branch_taken, id_is_hlt, mem_busy;
  logic pc_wen, if_id_wen, if_id_flush, id_ex_wen, id_ex_bubble, halted, timeout_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cycles, flush_count;
`endif
  int n_checks = 0;
  int n_fail = 0;
  bit m_halt_state, m_draining, m_halted, m_tmo;
  int m_streak, m_drained;
  int m_stall, m_flush;
  always #5 clk = ~clk;
  hazard_ctrl_unit #(.DRAIN_CYC(DRN), .MAX_WAIT(MAXW)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_src1_used (id_src1_used),
    .id_src2_used (id_src2_used),
    .ex_dst       (ex_dst),
    .ex_is_load   (ex_is_load),
    .branch_taken (branch_taken),
    .id_is_hlt    (id_is_hlt),
    .mem_busy     (mem_busy),
    .pc_wen       (pc_wen),
    .if_id_wen    (if_id_wen),
    .if_id_flush  (if_id_flush),
    .id_ex_wen    (id_ex_wen),
    .id_ex_bubble (id_ex_bubble),
    .halted       (halted),
    .timeout_err  (timeout_err)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    logic [4:0] exp;
    bit lu;
    #1;
    if (rst) begin
      {m_halt_state, m_draining, m_halted, m_tmo} = '0;
      m_streak = 0;
      m_drained = 0;
      m_stall = 0;
      m_flush = 0;
    end else begin
      lu = ex_is_load && ex_dst != 0 &&
           ((id_src1_used && id_src1 == ex_dst) || (id_src2_used && id_src2 == ex_dst));
      if (m_halt_state) exp = 5'b00000;
      else if (m_draining) exp = 5'b00011;
      else if (mem_busy) exp = 5'b00000;
      else if (lu) exp = 5'b00011;
      else if (branch_taken) exp = 5'b11110;
      else if (id_is_hlt) exp = 5'b00011;
      else exp = 5'b11010;
      check("ctrl{pc,ifid,flush,idex,bub}", {27'd0, pc_wen, if_id_wen, if_id_flush, id_ex_wen, id_ex_bubble}, {27'd0, exp});
      check("halted", {31'd0, halted}, {31'd0, m_halted});
      check("timeout_err", {31'd0, timeout_err}, {31'd0, m_tmo});
`ifdef HAZARD_PERF_CNT_EN
      check("stall_cycles", {16'd0, stall_cycles}, m_stall);
      check("flush_count", {16'd0, flush_count}, m_flush);
      if (!exp[4] && !m_halt_state && m_stall < 16'hFFFF) m_stall++;
      if (exp[2] && m_flush < 16'hFFFF) m_flush++;
`endif
      if (m_halt_state) begin
      end else if (m_draining) begin
        if (!mem_busy) m_drained++;
        if (m_drained == DRN) begin
          m_draining = 0;
          m_halt_state = 1;
          m_halted = 1;
        end
      end else if (mem_busy) begin
        m_streak++;
        if (m_streak > MAXW) m_tmo = 1;
      end else begin
        m_streak = 0;
        if (!lu && !branch_taken && id_is_hlt) begin
          m_draining = 1;
          m_drained = 0;
        end
      end
    end
    @(negedge clk);
  endtask
  task automatic drive(input bit b, input bit ld, input int dst, input int s1, input bit u1,
                       input int s2, input bit u2, input bit br, input bit h);
    mem_busy = b;
    ex_is_load = ld;
    ex_dst = 4'(dst);
    id_src1 = 4'(s1);
    id_src1_used = u1;
    id_src2 = 4'(s2);
    id_src2_used = u2;
    branch_taken = br;
    id_is_hlt = h;
    step();
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic busy(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic pulse_rst();
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    {mem_busy, ex_is_load, id_src1_used, id_src2_used, branch_taken, id_is_hlt} = '0;
    {ex_dst, id_src1, id_src2} = '0;
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    check("reset_halted", {31'd0, halted}, 32'd0);
    check("reset_timeout", {31'd0, timeout_err}, 32'd0);
    idle(1);
    drive(0, 1, 3, 3, 1, 1, 1, 0, 0);
    idle(1);
    drive(0, 1, 0, 0, 1, 0, 1, 0, 0);
    drive(0, 1, 4, 4, 0, 2, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 1, 7, 1, 0, 7, 1, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    busy(4);
    idle(2);
    check("no_timeout_4_busy", {31'd0, timeout_err}, 32'd0);
    busy(6);
    idle(1);
    check("timeout_6_busy", {31'd0, timeout_err}, 32'd1);
    pulse_rst();
    check("timeout_cleared", {31'd0, timeout_err}, 32'd0);
    idle(1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(DRN);
    check("halted_after_drain", {31'd0, halted}, 32'd1);
    idle(3);
    check("halted_sticky", {31'd0, halted}, 32'd1);
    pulse_rst();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    busy(1);
    idle(1);
    check("drain_busy_not_yet", {31'd0, halted}, 32'd0);
    idle(1);
    check("drain_busy_halted", {31'd0, halted}, 32'd1);
    pulse_rst();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    pulse_rst();
    check("rst_in_drain", {31'd0, halted}, 32'd0);
    idle(4);
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      drive($urandom_range(0, 99) < 15, $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 3);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
